seven_segment_driver: RTL and testbench
=======================================

Name: seven_segment_driver

Overview:
- Consumer end of the memory-mapped seven-segment register.
- Takes the 16-bit value the mmio block publishes as 4 hex digits, plus per-digit decimal points.
- Time-multiplexes the value onto a 4-digit common-anode/cathode display with brightness PWM and optional leading-zero blanking.
- Sits at top level between memory's seven_segment_out path and the board pins; updates are tear-free (applied only at frame boundaries).

Parameters:
- CLK_DIV_LOG2, 10: log2 of enabled-clock cycles per digit slot; must be >= 3.
- SEG_ACTIVE_LOW, 1: 1 means seg, dp and digit_en pins are active-low; 0 means active-high.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- clk_enable  input  1  global clock enable; all state advances only when high.
- value_in  input  16  four hex digits; digit 0 = [3:0], digit 3 = [15:12].
- dp_in  input  4  decimal point per digit.
- blank_lz  input  1  blank leading zero digits (sampled live, not latched).
- brightness  input  3  PWM duty in eighths minus one (0 = 1/8, 7 = always on).
- value_valid  input  1  request to load value_in/dp_in.
- value_ready  output  1  pending slot empty; equals !pending_full.
- seg  output  7  segments a..g, seg[0] = a.
- dp  output  1  decimal point of the active digit.
- digit_en  output  4  one-hot digit select.

Behaviour:
- Reset (rst_n low at a clk edge, clk_enable ignored):
  - prescaler = 0, digit index = 0.
  - Display value = 0, display dp = 0, pending_full = 0 (so value_ready = 1).
  - seg, dp and digit_en all driven inactive (all 1s when SEG_ACTIVE_LOW).
- Timing: nothing changes when clk_enable is low. The prescaler counts 0..2^CLK_DIV_LOG2-1 and wraps.
  - Prescaler wrap is the slot tick; the digit index then advances 0->1->2->3->0.
  - Index 3->0 on a tick is the frame boundary.
- Handshake:
  - Accept on a clk_enable edge with value_valid & value_ready: capture value_in/dp_in into the pending registers and set pending_full.
  - On a frame boundary with pending_full, copy pending to the display registers and clear pending_full.
  - An accept in the same cycle as a frame boundary (pending was empty) lands in pending and is displayed at the next frame boundary, not this one.
  - value_valid while not ready is ignored; the producer must hold it.
- Output stage (registered, one enabled cycle after index/prescaler state):
  - digit_en is one-hot at the current index while prescaler[CLK_DIV_LOG2-1 -: 3] <= brightness; otherwise all inactive.
  - Segments come from hex_to_seven_seg applied to the active nibble. Patterns: 0..9, A, b, C, d, E, F.
  - dp = display dp[index].
- Leading-zero blanking (blank_lz = 1):
  - Digit k (k >= 1) is blanked if display nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives all segments inactive but keeps its dp and its digit_en.
- Polarity: SEG_ACTIVE_LOW inverts seg, dp and digit_en at the output registers only.
- Reset mid-frame: all state returns to reset values the same edge; a pending update is discarded.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_WIDTH = 7 and NUM_DIGITS = 4.
  - Typedef seg_pattern_t (logic [6:0]).
  - Segment constants SEG_BLANK and SEG_HEX[0:15] (active-high).
- One combinational sub-module, hex_to_seven_seg: nibble in, seg_pattern_t out.
- Prescaler, handshake and output stage stay in the top module.

Test Plan:
- Reset then idle, CLK_DIV_LOG2=3, SEG_ACTIVE_LOW=1, brightness=7:
  - digit_en cycles 1110, 1101, 1011, 0111, each held 8 cycles.
  - seg = 7'b1000000 (0 pattern inverted) on every digit.
- Load 16'h12AF, dp_in 4'b0100 mid-frame:
  - value_ready falls next cycle.
  - Display unchanged until the index 3->0 tick.
  - Then digit0 = F, digit1 = A, digit2 = 2 with dp active, digit3 = 1; value_ready rises.
- Second value_valid while pending is full:
  - Ignored until the frame boundary.
  - The held request is accepted the cycle after ready rises.
- blank_lz=1 with 16'h0040:
  - Digits 3 and 2 show blank segments; digit1 = 4; digit0 = 0 (not blanked).
  - Value 16'h0000 shows only digit0 = 0.
- brightness=2, CLK_DIV_LOG2=4:
  - digit_en active for prescaler 0..5 (6 of 16 cycles) per slot, inactive for 6..15.
- clk_enable toggled 1-in-3 and rst_n pulsed low mid-slot with pending full:
  - Slot lengths scale by 3x.
  - After reset, outputs are inactive, index = 0, value_ready = 1, and the pending value is never displayed.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared widths, types and segment patterns for the seven-segment driver
package seven_seg_pkg;

    localparam int SEG_WIDTH  = 7;
    localparam int NUM_DIGITS = 4;

    typedef logic [SEG_WIDTH-1:0] seg_pattern_t;

    // Active-high patterns, bit 0 = segment a through bit 6 = segment g.
    localparam seg_pattern_t SEG_BLANK = 7'h00;
    localparam seg_pattern_t SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seven_segment_driver_hex.sv
// rtl/seven_segment_driver_hex.sv - nibble to active-high seven-segment pattern decoder
module hex_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0]   nibble,
    output seg_pattern_t pattern
);

    assign pattern = SEG_HEX[nibble];

endmodule

// File: rtl/seven_segment_driver.sv
// rtl/seven_segment_driver.sv - multiplexed 4-digit hex display with PWM, blanking and tear-free updates
module seven_segment_driver
    import seven_seg_pkg::*;
#(
    parameter int CLK_DIV_LOG2   = 10,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_enable,
    input  logic [15:0]           value_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  blank_lz,
    input  logic [2:0]            brightness,
    input  logic                  value_valid,
    output logic                  value_ready,
    output logic [SEG_WIDTH-1:0]  seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_en
);

    // XOR masks: all-ones flips to active-low, and doubles as the inactive level.
    localparam logic [SEG_WIDTH-1:0]  SEG_OFF = {SEG_WIDTH{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DEN_OFF = {NUM_DIGITS{SEG_ACTIVE_LOW}};

    logic [CLK_DIV_LOG2-1:0] prescaler;
    logic [1:0]              digit_idx;
    logic [15:0]             pending_value;
    logic [15:0]             display_value;
    logic [NUM_DIGITS-1:0]   pending_dp;
    logic [NUM_DIGITS-1:0]   display_dp;
    logic                    pending_full;

    logic                    slot_tick;
    logic                    frame_tick;
    logic                    accept;
    logic [3:0]              active_nibble;
    logic                    blank_digit;
    logic                    pwm_on;
    seg_pattern_t            hex_pattern;
    seg_pattern_t            seg_next;
    logic [NUM_DIGITS-1:0]   den_next;

    assign slot_tick   = &prescaler;
    assign frame_tick  = slot_tick && (digit_idx == 2'd3);
    assign value_ready = !pending_full;
    assign accept      = value_valid && !pending_full;

    assign active_nibble = display_value[{digit_idx, 2'b00} +: 4];

    // A digit is leading-zero if it and every more significant nibble are zero.
    assign blank_digit = blank_lz && (digit_idx != 2'd0)
                         && ~|(display_value >> {digit_idx, 2'b00});

    assign pwm_on = prescaler[CLK_DIV_LOG2-1 -: 3] <= brightness;

    hex_to_seven_seg u_hex (
        .nibble  (active_nibble),
        .pattern (hex_pattern)
    );

    assign seg_next = blank_digit ? SEG_BLANK : hex_pattern;
    assign den_next = pwm_on ? (4'b0001 << digit_idx) : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler     <= '0;
            digit_idx     <= 2'd0;
            pending_value <= '0;
            pending_dp    <= '0;
            display_value <= '0;
            display_dp    <= '0;
            pending_full  <= 1'b0;
            seg           <= SEG_OFF;
            dp            <= DP_OFF;
            digit_en      <= DEN_OFF;
        end else if (clk_enable) begin
            prescaler <= prescaler + 1'b1;
            if (slot_tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
            // A full pending slot blocks accept, so copy-out and capture never collide.
            if (frame_tick && pending_full) begin
                display_value <= pending_value;
                display_dp    <= pending_dp;
                pending_full  <= 1'b0;
            end else if (accept) begin
                pending_value <= value_in;
                pending_dp    <= dp_in;
                pending_full  <= 1'b1;
            end
            seg      <= seg_next ^ SEG_OFF;
            dp       <= display_dp[digit_idx] ^ DP_OFF;
            digit_en <= den_next ^ DEN_OFF;
        end
    end

endmodule

// File: tb/tb_seven_segment_driver.sv
// tb/tb_seven_segment_driver.sv - scoreboard bench for seven_segment_driver at two divider/polarity settings
module tb_seven_segment_driver;

    typedef logic [12:0] exp_t;

    localparam logic [6:0] HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_enable = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [2:0]  brightness = 3'd7;
    logic        value_valid = 1'b0;

    logic       rdy0, dp0, rdy1, dp1;
    logic [6:0] seg0, seg1;
    logic [3:0] den0, den1;

    int n_checks = 0;
    int n_pass   = 0;

    int          m_pre  [2];
    int          m_idx  [2];
    logic [15:0] m_disp [2];
    logic [15:0] m_pval [2];
    logic [3:0]  m_ddp  [2];
    logic [3:0]  m_pdp  [2];
    logic        m_full [2];
    logic [11:0] m_out  [2];
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;

    seven_segment_driver #(.CLK_DIV_LOG2(3), .SEG_ACTIVE_LOW(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .value_in(value_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .brightness(brightness),
        .value_valid(value_valid), .value_ready(rdy0), .seg(seg0), .dp(dp0),
        .digit_en(den0)
    );

    seven_segment_driver #(.CLK_DIV_LOG2(4), .SEG_ACTIVE_LOW(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .value_in(value_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .brightness(brightness),
        .value_valid(value_valid), .value_ready(rdy1), .seg(seg1), .dp(dp1),
        .digit_en(den1)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model of one instance; k=0 is div 3 active-low, k=1 is div 4 active-high.
    task automatic model_step(input int k);
        int          div;
        logic [15:0] upper;
        logic [6:0]  s;
        logic [3:0]  en;
        logic        d;
        bit          blank, tick;
        div = (k == 0) ? 3 : 4;
        if (!rst_n) begin
            m_pre[k] = 0; m_idx[k] = 0; m_disp[k] = '0; m_ddp[k] = '0;
            m_pval[k] = '0; m_pdp[k] = '0; m_full[k] = 1'b0;
            m_out[k] = (k == 0) ? 12'hFFF : 12'h000;
        end else if (clk_enable) begin
            upper = m_disp[k] >> (4 * m_idx[k]);
            blank = blank_lz && (m_idx[k] != 0) && (upper == 16'h0);
            s     = blank ? 7'h00 : HEX[upper[3:0]];
            en    = ((m_pre[k] >> (div - 3)) <= int'(brightness)) ? 4'(1 << m_idx[k]) : 4'h0;
            d     = m_ddp[k][m_idx[k]];
            m_out[k] = (k == 0) ? ~{s, d, en} : {s, d, en};
            tick  = (m_pre[k] == (1 << div) - 1);
            if (tick && m_idx[k] == 3 && m_full[k]) begin
                m_disp[k] = m_pval[k]; m_ddp[k] = m_pdp[k]; m_full[k] = 1'b0;
            end else if (value_valid && !m_full[k]) begin
                m_pval[k] = value_in; m_pdp[k] = dp_in; m_full[k] = 1'b1;
            end
            m_pre[k] = (m_pre[k] + 1) % (1 << div);
            if (tick) m_idx[k] = (m_idx[k] + 1) % 4;
        end
    endtask

    task automatic tick();
        exp_t e0, e1;
        model_step(0);
        model_step(1);
        q0.push_back({m_out[0], ~m_full[0]});
        q1.push_back({m_out[1], ~m_full[1]});
        @(posedge clk);
        #1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check("sb_div3_low", {3'b0, seg0, dp0, den0, rdy0}, {3'b0, e0});
        check("sb_div4_high", {3'b0, seg1, dp1, den1, rdy1}, {3'b0, e1});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_den0(input logic [3:0] target);
        int budget;
        budget = 40;
        while (den0 !== target && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("wait_digit_timeout", {12'h0, den0}, {12'h0, target});
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        value_in = v; dp_in = d; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    initial begin
        run(3);
        rst_n = 1'b1;
        run(40);

        load(16'h12AF, 4'b0100);
        check("ready_fall", {15'h0, rdy0}, 16'h0);
        run(70);
        wait_den0(4'b1011);
        check("digit2_seg", {9'h0, seg0}, {9'h0, 7'b0100100});
        check("digit2_dp", {15'h0, dp0}, 16'h0);

        load(16'h3456, 4'b0001);
        value_in = 16'h789A; dp_in = 4'b1000; value_valid = 1'b1;
        run(80);
        value_valid = 1'b0;
        run(70);

        blank_lz = 1'b1;
        load(16'h0040, 4'b0000);
        run(70);
        wait_den0(4'b0111);
        check("blank_digit3", {9'h0, seg0}, {9'h0, 7'h7F});
        load(16'h0000, 4'b0000);
        run(70);
        wait_den0(4'b1110);
        check("zero_digit0", {9'h0, seg0}, {9'h0, 7'b1000000});
        wait_den0(4'b1101);
        check("zero_digit1_blank", {9'h0, seg0}, {9'h0, 7'h7F});

        brightness = 3'd2;
        load(16'hC3D5, 4'b1010);
        run(70);
        brightness = 3'd0;
        blank_lz = 1'b0;
        run(40);
        brightness = 3'd7;

        value_in = 16'hBEEF; dp_in = 4'b1111;
        for (int i = 0; i < 120; i++) begin
            clk_enable = (i % 3 == 0);
            value_valid = (i >= 100 && i < 106);
            tick();
        end
        value_valid = 1'b0;
        clk_enable = 1'b0;
        rst_n = 1'b0;
        tick();
        check("reset_ready", {15'h0, rdy0}, 16'h1);
        check("reset_den", {12'h0, den0}, 16'h000F);
        rst_n = 1'b1;
        for (int i = 0; i < 90; i++) begin
            clk_enable = (i % 3 == 0);
            tick();
        end
        clk_enable = 1'b1;
        run(70);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
